fifo_sync_param: RTL and testbench

Parametrised single-clock synchronous FIFO, the next generation of the team's sync FIFO. It adds configurable depth, configurable almost-full/almost-empty thresholds, an occupancy count output, and a selectable first-word-fall-through (FWFT) read mode. It keeps the existing handshake and status signal set, and sits between a producer and consumer on the same clock domain.

---
 rtl/fifo_sync_param_if.sv | 51 +++++
 rtl/fifo_sync_param.sv | 128 ++++++++++++
 tb/tb_fifo_sync_param.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bundle for fifo_sync_param: write and read handshakes, read data and
// occupancy status. The FIFO takes the slave side; the driving agent takes the master side.
interface fifo_sync_param_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CW    = 4
) ();

    logic [WIDTH-1:0] data_in;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             wr_ack;
    logic             overflow;
    logic             underflow;
    logic             full;
    logic             empty;
    logic             almostfull;
    logic             almostempty;
    logic [CW-1:0]    count;

    modport master (
        output data_in,
        output wr_en,
        output rd_en,
        input  data_out,
        input  wr_ack,
        input  overflow,
        input  underflow,
        input  full,
        input  empty,
        input  almostfull,
        input  almostempty,
        input  count
    );

    modport slave (
        input  data_in,
        input  wr_en,
        input  rd_en,
        output data_out,
        output wr_ack,
        output overflow,
        output underflow,
        output full,
        output empty,
        output almostfull,
        output almostempty,
        output count
    );

endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds and a
// selectable registered or first-word-fall-through read port.
module fifo_sync_param #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int unsigned AE_LEVEL   = 1,
    parameter int unsigned FWFT       = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_sync_param_if.slave fifo_io
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    if (FIFO_WIDTH < 1) begin : g_bad_width
        $error("fifo_sync_param: FIFO_WIDTH must be at least 1");
    end
    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $error("fifo_sync_param: FIFO_DEPTH must be at least 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH) begin : g_bad_af
        $error("fifo_sync_param: AF_LEVEL out of range 1..FIFO_DEPTH");
    end
    if (AE_LEVEL > FIFO_DEPTH - 1) begin : g_bad_ae
        $error("fifo_sync_param: AE_LEVEL out of range 0..FIFO_DEPTH-1");
    end

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_ack_q, wr_ack_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic full, empty;
    logic wr_ok, rd_ok;

    // Explicit wrap so non-power-of-two depths never index past the array.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(FIFO_DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);

    // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
    assign rd_ok = fifo_io.rd_en && !empty;
    assign wr_ok = fifo_io.wr_en && (!full || rd_ok);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wr_ack_d    = wr_ok;
        overflow_d  = fifo_io.wr_en && !wr_ok;
        underflow_d = fifo_io.rd_en && !rd_ok;

        if (wr_ok) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (rd_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; requests in a reset cycle are ignored.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) begin
            mem_q[wr_ptr_q] <= fifo_io.data_in;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is always on display; it is stale while the FIFO is empty.
        assign fifo_io.data_out = mem_q[rd_ptr_q];
    end else begin : g_std
        logic [FIFO_WIDTH-1:0] data_out_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                data_out_q <= '0;
            end else if (rd_ok) begin
                data_out_q <= mem_q[rd_ptr_q];
            end
        end

        assign fifo_io.data_out = data_out_q;
    end

    assign fifo_io.wr_ack      = wr_ack_q;
    assign fifo_io.overflow    = overflow_q;
    assign fifo_io.underflow   = underflow_q;
    assign fifo_io.full        = full;
    assign fifo_io.empty       = empty;
    assign fifo_io.almostfull  = (count_q >= CW'(AF_LEVEL));
    assign fifo_io.almostempty = (count_q <= CW'(AE_LEVEL));
    assign fifo_io.count       = count_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Drives three FIFO configurations in lockstep and checks every output each cycle against a
// queue-based model of the FIFO's accept/reject rules.
module tb_fifo_sync_param;

    localparam int unsigned W = 16;
    localparam int          N = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_en;
    logic         rd_en;
    logic [W-1:0] din;

    always #5 clk = ~clk;

    fifo_sync_param_if #(.WIDTH(W), .CW(4)) if_a ();
    fifo_sync_param_if #(.WIDTH(W), .CW(4)) if_b ();
    fifo_sync_param_if #(.WIDTH(W), .CW(3)) if_c ();

    assign if_a.data_in = din;
    assign if_a.wr_en   = wr_en;
    assign if_a.rd_en   = rd_en;
    assign if_b.data_in = din;
    assign if_b.wr_en   = wr_en;
    assign if_b.rd_en   = rd_en;
    assign if_c.data_in = din;
    assign if_c.wr_en   = wr_en;
    assign if_c.rd_en   = rd_en;

    fifo_sync_param #(
        .FIFO_WIDTH(W), .FIFO_DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1), .FWFT(0)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .fifo_io(if_a.slave)
    );

    fifo_sync_param #(
        .FIFO_WIDTH(W), .FIFO_DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1), .FWFT(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .fifo_io(if_b.slave)
    );

    fifo_sync_param #(
        .FIFO_WIDTH(W), .FIFO_DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(2), .FWFT(0)
    ) u_dut_c (
        .clk(clk), .rst_n(rst_n), .fifo_io(if_c.slave)
    );

    // Observed outputs gathered per instance: flags are
    // {wr_ack, overflow, underflow, full, empty, almostfull, almostempty}.
    logic [W-1:0] o_dout [N];
    logic [31:0]  o_cnt  [N];
    logic [6:0]   o_fl   [N];

    assign o_dout[0] = if_a.data_out;
    assign o_dout[1] = if_b.data_out;
    assign o_dout[2] = if_c.data_out;
    assign o_cnt[0]  = 32'(if_a.count);
    assign o_cnt[1]  = 32'(if_b.count);
    assign o_cnt[2]  = 32'(if_c.count);
    assign o_fl[0]   = {if_a.wr_ack, if_a.overflow, if_a.underflow, if_a.full, if_a.empty,
                        if_a.almostfull, if_a.almostempty};
    assign o_fl[1]   = {if_b.wr_ack, if_b.overflow, if_b.underflow, if_b.full, if_b.empty,
                        if_b.almostfull, if_b.almostempty};
    assign o_fl[2]   = {if_c.wr_ack, if_c.overflow, if_c.underflow, if_c.full, if_c.empty,
                        if_c.almostfull, if_c.almostempty};

    int dep  [N];
    int af   [N];
    int ae   [N];
    int fwft [N];

    logic [W-1:0] q [N][$];
    logic [W-1:0] m_dout [N];
    logic         m_ack  [N];
    logic         m_ovf  [N];
    logic         m_udf  [N];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            int           sz;
            bit           rok;
            bit           wok;
            logic [W-1:0] popped;
            if (!rst_n) begin
                q[i].delete();
                m_ack[i] = 1'b0;
                m_ovf[i] = 1'b0;
                m_udf[i] = 1'b0;
                if (fwft[i] == 0) m_dout[i] = '0;
            end else begin
                sz  = q[i].size();
                rok = rd_en && (sz > 0);
                wok = wr_en && ((sz < dep[i]) || rok);
                if (rok) begin
                    popped = q[i].pop_front();
                    if (fwft[i] == 0) m_dout[i] = popped;
                end
                if (wok) q[i].push_back(din);
                m_ack[i] = wok;
                m_ovf[i] = wr_en && !wok;
                m_udf[i] = rd_en && !rok;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            int   sz;
            logic [6:0] exp_fl;
            sz = q[i].size();
            exp_fl = {m_ack[i], m_ovf[i], m_udf[i], sz == dep[i], sz == 0, sz >= af[i],
                      sz <= ae[i]};
            chk($sformatf("dut%0d count", i), o_cnt[i], 32'(sz));
            chk($sformatf("dut%0d wr_ack", i), 32'(o_fl[i][6]), 32'(exp_fl[6]));
            chk($sformatf("dut%0d overflow", i), 32'(o_fl[i][5]), 32'(exp_fl[5]));
            chk($sformatf("dut%0d underflow", i), 32'(o_fl[i][4]), 32'(exp_fl[4]));
            chk($sformatf("dut%0d full", i), 32'(o_fl[i][3]), 32'(exp_fl[3]));
            chk($sformatf("dut%0d empty", i), 32'(o_fl[i][2]), 32'(exp_fl[2]));
            chk($sformatf("dut%0d almostfull", i), 32'(o_fl[i][1]), 32'(exp_fl[1]));
            chk($sformatf("dut%0d almostempty", i), 32'(o_fl[i][0]), 32'(exp_fl[0]));
            if (fwft[i] == 0) begin
                chk($sformatf("dut%0d data_out", i), 32'(o_dout[i]), 32'(m_dout[i]));
            end else if (sz > 0) begin
                chk($sformatf("dut%0d data_out head", i), 32'(o_dout[i]), 32'(q[i][0]));
            end
        end
    endtask

    // Inputs change 1 time unit after an edge and are sampled at the next one.
    task automatic drive(input bit w, input bit r, input logic [W-1:0] d);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        dep  = '{8, 8, 5};
        af   = '{7, 7, 3};
        ae   = '{1, 1, 2};
        fwft = '{0, 1, 0};
        for (int i = 0; i < N; i++) begin
            m_dout[i] = '0;
            m_ack[i]  = 1'b0;
            m_ovf[i]  = 1'b0;
            m_udf[i]  = 1'b0;
        end
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;

        // Reset, then one idle cycle.
        drive(1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, '0);

        // Fill to full, then one write too many.
        for (int k = 1; k <= 8; k++) drive(1'b1, 1'b0, W'(k));
        drive(1'b1, 1'b0, 16'hDEAD);
        drive(1'b0, 1'b0, '0);

        // Simultaneous write and read while full.
        drive(1'b1, 1'b1, 16'h00AA);

        // Drain everything, then read past empty.
        for (int k = 0; k < 9; k++) drive(1'b0, 1'b1, '0);

        // Simultaneous write and read while empty.
        drive(1'b1, 1'b1, 16'h0055);
        drive(1'b0, 1'b1, '0);
        drive(1'b0, 1'b1, '0);

        // Interleaved traffic wrapping the pointers.
        for (int k = 0; k < 24; k++) begin
            drive(1'((k % 3) != 2), 1'((k % 2) == 1), W'(32'h0100 + k));
        end

        // Reset in the middle of traffic with both requests asserted.
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, W'(32'h0200 + k));
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 16'hBEEF);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, '0);
        drive(1'b0, 1'b1, '0);

        // Random traffic: write-heavy, then read-heavy, with rare resets.
        for (int k = 0; k < 400; k++) begin
            bit w;
            bit r;
            rst_n = ($urandom_range(0, 63) != 0);
            if (k < 200) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            drive(w, r, W'($urandom));
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
